// File: rtl/mem_image_loader.sv
// mem_image_loader: copies a byte image from a read-only source into the banked
// main-memory array. The destination byte address is split as {row, line, col, byte}.
// Source bytes are fetched one per cycle and packed into a word. The packed word
// is then written with per-lane enables.
// Optional feature macro: MEM_IMAGE_LOADER_CKSUM_EN
//   defined   -> cksum is a 16-bit running sum of every byte actually written
//   undefined -> cksum is tied to 0
module mem_image_loader #(
   parameter  int ROW_W  = 3,
   parameter  int COL_W  = 3,
   parameter  int LINE_W = 7,
   parameter  int BIDX_W = 2,
   parameter  int SRC_AW = 12,
   localparam int ADDR_W = ROW_W + LINE_W + COL_W + BIDX_W,
   localparam int BYTES  = 2 ** BIDX_W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                abort,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [SRC_AW-1:0]   src_base,
   input  logic [ADDR_W:0]     num_bytes,
   output logic                src_req,
   output logic [SRC_AW-1:0]   src_addr,
   input  logic [7:0]          src_data,
   output logic                mem_wr_req,
   input  logic                mem_wr_ack,
   output logic [ROW_W-1:0]    mem_row,
   output logic [COL_W-1:0]    mem_col,
   output logic [LINE_W-1:0]   mem_line,
   output logic [BYTES-1:0]    mem_be,
   output logic [8*BYTES-1:0]  mem_wdata,
   output logic                busy,
   output logic                done,
   output logic                error,
   output logic [15:0]         cksum
);

   localparam int                WORD_W    = ADDR_W - BIDX_W;
   localparam logic [BIDX_W-1:0] LAST_LANE = '1;
   localparam logic [ADDR_W+1:0] LIMIT     = {2'b01, {ADDR_W{1'b0}}};

   typedef enum logic [2:0] {IDLE, CHECK, FETCH, WRITE, DONE} state_t;

   state_t                  state;
   logic [WORD_W-1:0]       word_q;    // {row, line, col} of the word being built
   logic [BIDX_W-1:0]       lane_q;    // lane of the next byte to request
   logic [ADDR_W:0]         rem_q;     // bytes not yet requested
   logic                    vld_p1;    // a source byte arrives this cycle
   logic [BIDX_W-1:0]       lane_p1;   // lane that arriving byte belongs to
   logic                    abort_q;   // abort seen while a write is pending
   logic [BYTES-1:0][7:0]   pack_q;
   logic [BYTES-1:0]        be_q;
   logic [ADDR_W+1:0]       end_addr;
   logic                    range_err;

   // One past the last destination byte; must not exceed the array size
   assign end_addr  = {2'b00, word_q, lane_q} + {1'b0, rem_q};
   assign range_err = end_addr > LIMIT;

   assign mem_wdata = pack_q;
   assign mem_be    = be_q;
   assign mem_col   = word_q[COL_W-1:0];
   assign mem_line  = word_q[COL_W +: LINE_W];
   assign mem_row   = word_q[COL_W+LINE_W +: ROW_W];

`ifdef MEM_IMAGE_LOADER_CKSUM_EN
   logic [15:0] cksum_q;
   assign cksum = cksum_q;

   // Modulo-2^16 sum of the enabled lanes of a word
   function automatic logic [15:0] ck_add(input logic [15:0] sum,
                                          input logic [BYTES-1:0][7:0] d,
                                          input logic [BYTES-1:0] be);
      logic [15:0] s;
      s = sum;
      for (int i = 0; i < BYTES; i++)
         if (be[i]) s = s + {8'h00, d[i]};
      return s;
   endfunction
`else
   assign cksum = '0;
`endif

   // Copy sequencer: CHECK validates the request, FETCH streams bytes into the
   // pack register, WRITE holds the word until acknowledged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         word_q     <= '0;
         lane_q     <= '0;
         rem_q      <= '0;
         vld_p1     <= 1'b0;
         lane_p1    <= '0;
         abort_q    <= 1'b0;
         pack_q     <= '0;
         be_q       <= '0;
         src_req    <= 1'b0;
         src_addr   <= '0;
         mem_wr_req <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         error      <= 1'b0;
`ifdef MEM_IMAGE_LOADER_CKSUM_EN
         cksum_q    <= '0;
`endif
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= CHECK;
                  busy     <= 1'b1;
                  error    <= 1'b0;
                  abort_q  <= 1'b0;
                  word_q   <= base_addr[ADDR_W-1:BIDX_W];
                  lane_q   <= base_addr[BIDX_W-1:0];
                  rem_q    <= num_bytes;
                  src_addr <= src_base;
`ifdef MEM_IMAGE_LOADER_CKSUM_EN
                  cksum_q  <= '0;
`endif
               end
            end
            CHECK: begin
               if (rem_q == 0) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else if (range_err) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  error <= 1'b1;
               end else begin
                  state   <= FETCH;
                  src_req <= 1'b1;
               end
            end
            FETCH: begin
               // capture the byte requested last cycle
               if (vld_p1) begin
                  pack_q[lane_p1] <= src_data;
                  be_q[lane_p1]   <= 1'b1;
               end
               vld_p1  <= src_req;
               lane_p1 <= lane_q;
               if (abort) begin
                  // partial word is dropped, nothing is written
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  src_req <= 1'b0;
                  vld_p1  <= 1'b0;
                  pack_q  <= '0;
                  be_q    <= '0;
               end else if (src_req) begin
                  src_addr <= src_addr + 1'b1;
                  rem_q    <= rem_q - 1'b1;
                  if (lane_q == LAST_LANE || rem_q == 1)
                     src_req <= 1'b0;
                  else
                     lane_q <= lane_q + 1'b1;
               end else if (vld_p1) begin
                  state      <= WRITE;
                  mem_wr_req <= 1'b1;
               end
            end
            WRITE: begin
               if (abort) abort_q <= 1'b1;
               if (mem_wr_ack) begin
                  mem_wr_req <= 1'b0;
                  pack_q     <= '0;
                  be_q       <= '0;
`ifdef MEM_IMAGE_LOADER_CKSUM_EN
                  cksum_q    <= ck_add(cksum_q, pack_q, be_q);
`endif
                  if (rem_q != 0 && !abort && !abort_q) begin
                     state   <= FETCH;
                     word_q  <= word_q + 1'b1;
                     lane_q  <= '0;
                     src_req <= 1'b1;
                  end else begin
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
